// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters.
// Latches the winner's byte for the whole frame, acks on completion, flags a transmitter that never goes busy.
module uart_tx_arbiter #(
   parameter int N            = 4,
   parameter int GW           = 2,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] req_data,
   output logic [N-1:0]   ack,
   output logic [GW-1:0]  grant_id,
   output logic           active,
   output logic           tx_ena,
   output logic           tx_send,
   output logic [7:0]     tx_data,
   input  logic           tx_busy,
   output logic           timeout_err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [GW:0]   NW   = (GW+1)'(N);
   localparam logic [GW-1:0] LAST = GW'(N-1);
   localparam logic [7:0]    TMO  = 8'(BUSY_TIMEOUT);

   state_t         state_q, state_d;
   logic [GW-1:0]  ptr_q, ptr_d;
   logic [N-1:0]   ack_q, ack_d;
   logic [GW-1:0]  grant_q, grant_d;
   logic           active_q, active_d;
   logic           ena_q;
   logic           send_q, send_d;
   logic [7:0]     data_q, data_d;
   logic [7:0]     timer_q, timer_d;
   logic           terr_q, terr_d;

   logic           sel_found;
   logic [GW-1:0]  sel_idx;
   logic [GW:0]    cand;
   logic [7:0]     sel_byte;
   logic [GW-1:0]  ptr_nxt;

   // Search ptr, ptr+1, ... with wrap; first requesting index wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + (GW+1)'(k);
         if (cand >= NW) cand = cand - NW;
         for (int j = 0; j < N; j++) begin
            if (!sel_found && (cand == (GW+1)'(j)) && req[j]) begin
               sel_found = 1'b1;
               sel_idx   = GW'(j);
            end
         end
      end
      sel_byte = '0;
      for (int k = 0; k < N; k++) begin
         if (sel_idx == GW'(k)) sel_byte = req_data[8*k +: 8];
      end
   end

   assign ptr_nxt = (grant_q == LAST) ? '0 : grant_q + GW'(1);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      ack_d    = '0;
      grant_d  = grant_q;
      active_d = active_q;
      send_d   = 1'b0;
      data_d   = data_q;
      timer_d  = timer_q;
      terr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            // The transmitter reports busy while initialising, so busy also gates launch.
            if (ena_q && !tx_busy && sel_found) begin
               data_d   = sel_byte;
               grant_d  = sel_idx;
               active_d = 1'b1;
               send_d   = 1'b1;
               state_d  = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (timer_q == TMO) begin
               terr_d   = 1'b1;
               active_d = 1'b0;
               ptr_d    = ptr_nxt;
               state_d  = IDLE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               for (int k = 0; k < N; k++) begin
                  if (grant_q == GW'(k)) ack_d[k] = 1'b1;
               end
               active_d = 1'b0;
               ptr_d    = ptr_nxt;
               state_d  = IDLE;
            end
         end
         default: begin
            active_d = 1'b0;
            state_d  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         ack_q    <= '0;
         grant_q  <= '0;
         active_q <= 1'b0;
         ena_q    <= 1'b0;
         send_q   <= 1'b0;
         data_q   <= 8'h00;
         timer_q  <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         ack_q    <= ack_d;
         grant_q  <= grant_d;
         active_q <= active_d;
         ena_q    <= 1'b1;
         send_q   <= send_d;
         data_q   <= data_d;
         timer_q  <= timer_d;
         terr_q   <= terr_d;
      end
   end

   assign ack         = ack_q;
   assign grant_id    = grant_q;
   assign active      = active_q;
   assign tx_ena      = ena_q;
   assign tx_send     = send_q;
   assign tx_data     = data_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model (1-cycle init busy, 10-cycle frames).
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int GW = 2;
   localparam int BT = 15;
   localparam int FRAME_LEN = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   ack;
   logic [GW-1:0]  grant_id;
   logic           active;
   logic           tx_ena;
   logic           tx_send;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic           timeout_err;

   int tests_run = 0;
   int tests_failed = 0;

   // transmitter model
   logic mb = 1'b0;
   int   mcnt = 0;
   logic ena_d1 = 1'b0;
   logic dead = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ena_d1 <= tx_ena;
      if (!tx_ena) begin
         mb   <= 1'b0;
         mcnt <= 0;
      end else if (tx_send && !mb && !dead) begin
         mb   <= 1'b1;
         mcnt <= FRAME_LEN - 1;
      end else if (mb) begin
         if (mcnt == 0) mb <= 1'b0;
         else mcnt <= mcnt - 1;
      end
   end

   assign tx_busy = mb | (tx_ena & ~ena_d1);

   uart_tx_arbiter #(.N(N), .GW(GW), .BUSY_TIMEOUT(BT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
      .grant_id(grant_id), .active(active), .tx_ena(tx_ena), .tx_send(tx_send),
      .tx_data(tx_data), .tx_busy(tx_busy), .timeout_err(timeout_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // which: 0 = tx_send, 1 = any ack, 2 = timeout_err
   task automatic wait_sig(input int which, input int limit, output int cyc, output bit hit);
      hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < limit) begin
         @(negedge clk);
         cyc++;
         case (which)
            0:       hit = (tx_send === 1'b1);
            1:       hit = (ack !== '0);
            default: hit = (timeout_err === 1'b1);
         endcase
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; req_data = '0;
      repeat (2) @(negedge clk);
      tests_run++; if (ack !== 4'b0) begin tests_failed++; $display("FAIL reset_ack: got %0h expected 0", ack); end
      tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %0b expected 0", active); end
      tests_run++; if (tx_ena !== 1'b0) begin tests_failed++; $display("FAIL reset_ena: got %0b expected 0", tx_ena); end
      tests_run++; if (tx_send !== 1'b0) begin tests_failed++; $display("FAIL reset_send: got %0b expected 0", tx_send); end
      tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h expected 00", tx_data); end
      tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_terr: got %0b expected 0", timeout_err); end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++; if (tx_ena !== 1'b1) begin tests_failed++; $display("FAIL reset_ena_rise: got %0b expected 1", tx_ena); end
   endtask

   task automatic test_startup();
      int first;
      int cyc;
      bit hit;
      rst_n = 1'b0; req = 4'b0001; req_data = '0; req_data[7:0] = 8'h5A;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first = 0;
      for (int c = 1; c <= 8 && first == 0; c++) begin
         @(negedge clk);
         if (tx_send === 1'b1) first = c;
      end
      tests_run++; if (first != 3) begin tests_failed++; $display("FAIL startup_send_cycle: got %0d expected 3", first); end
      tests_run++; if (tx_data !== 8'h5A) begin tests_failed++; $display("FAIL startup_data: got %0h expected 5a", tx_data); end
      wait_sig(1, 20, cyc, hit);
      tests_run++; if (ack !== 4'b0001) begin tests_failed++; $display("FAIL startup_ack: got %0h expected 1 (hit=%0b)", ack, hit); end
      req = '0;
   endtask

   task automatic test_single();
      int sends;
      int c;
      repeat (2) @(negedge clk);
      req = 4'b0100; req_data[23:16] = 8'hA5;
      @(negedge clk);
      tests_run++; if (tx_send !== 1'b1) begin tests_failed++; $display("FAIL single_latency: got %0b expected 1", tx_send); end
      tests_run++; if (grant_id !== 2'd2) begin tests_failed++; $display("FAIL single_grant: got %0d expected 2", grant_id); end
      tests_run++; if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %0h expected a5", tx_data); end
      tests_run++; if (active !== 1'b1) begin tests_failed++; $display("FAIL single_active: got %0b expected 1", active); end
      sends = 0;
      c = 0;
      while (c < 20) begin
         @(negedge clk);
         c++;
         if (tx_send === 1'b1) sends++;
         if (ack !== '0) break;
         tests_run++; if (tx_data !== 8'hA5) begin tests_failed++; $display("FAIL single_stable: got %0h expected a5 at cycle %0d", tx_data, c); end
      end
      tests_run++; if (c != 12) begin tests_failed++; $display("FAIL single_ack_cycle: got %0d expected 12", c); end
      tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL single_ack: got %0h expected 4", ack); end
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL single_active_fall: got %0b expected 0", active); end
      tests_run++; if (sends != 0) begin tests_failed++; $display("FAIL single_extra_send: got %0d expected 0", sends); end
      req = '0;
      @(negedge clk);
      tests_run++; if (ack !== 4'b0) begin tests_failed++; $display("FAIL single_ack_once: got %0h expected 0", ack); end
   endtask

   task automatic test_round_robin();
      int cyc;
      bit hit;
      logic [1:0] e;
      logic [7:0] eb;
      logic [3:0] ea;
      rst_n = 1'b0; req = 4'b1111; req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_sig(0, 10, cyc, hit);
      tests_run++; if (!hit) begin tests_failed++; $display("FAIL rr_first_send: got none expected tx_send"); end
      for (int f = 0; f < 5; f++) begin
         e  = 2'(f % 4);
         eb = 8'((f % 4 + 1) * 17);
         ea = 4'b0001 << e;
         tests_run++; if (grant_id !== e) begin tests_failed++; $display("FAIL rr_grant: got %0d expected %0d (frame %0d)", grant_id, e, f); end
         tests_run++; if (tx_data !== eb) begin tests_failed++; $display("FAIL rr_data: got %0h expected %0h (frame %0d)", tx_data, eb, f); end
         wait_sig(1, 20, cyc, hit);
         tests_run++; if (ack !== ea) begin tests_failed++; $display("FAIL rr_ack: got %0h expected %0h (frame %0d)", ack, ea, f); end
         tests_run++; if (tx_send !== 1'b0) begin tests_failed++; $display("FAIL rr_ack_send_overlap: got %0b expected 0", tx_send); end
         if (f < 4) begin
            @(negedge clk);
            tests_run++; if (tx_send !== 1'b1) begin tests_failed++; $display("FAIL rr_b2b: got %0b expected 1 (frame %0d)", tx_send, f + 1); end
         end else begin
            req = '0;
         end
      end
   endtask

   task automatic test_withdraw();
      int cyc;
      bit hit;
      int c;
      @(negedge clk);
      req = 4'b1000; req_data[31:24] = 8'h77;
      wait_sig(0, 5, cyc, hit);
      tests_run++; if (grant_id !== 2'd3 || !hit) begin tests_failed++; $display("FAIL wd_grant: got %0d expected 3 (hit=%0b)", grant_id, hit); end
      repeat (3) @(negedge clk);
      req = 4'b0010; req_data[31:24] = 8'hEE; req_data[15:8] = 8'hBB;
      @(negedge clk);
      req = '0;
      c = 0;
      while (c < 20 && ack === '0) begin
         tests_run++; if (tx_data !== 8'h77) begin tests_failed++; $display("FAIL wd_data_held: got %0h expected 77", tx_data); end
         @(negedge clk);
         c++;
      end
      tests_run++; if (ack !== 4'b1000) begin tests_failed++; $display("FAIL wd_ack3: got %0h expected 8", ack); end
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         tests_run++; if (tx_send !== 1'b0 || ack !== '0) begin tests_failed++; $display("FAIL wd_no_req1: got send=%0b ack=%0h expected 0/0", tx_send, ack); end
      end
      tests_run++; if (tx_data !== 8'h77) begin tests_failed++; $display("FAIL wd_idle_data: got %0h expected 77", tx_data); end
      tests_run++; if (grant_id !== 2'd3) begin tests_failed++; $display("FAIL wd_idle_grant: got %0d expected 3", grant_id); end
   endtask

   task automatic test_timeout();
      int cyc;
      bit hit;
      int c;
      dead = 1'b1;
      req = 4'b0001; req_data[7:0] = 8'h3C;
      wait_sig(0, 5, cyc, hit);
      tests_run++; if (!hit) begin tests_failed++; $display("FAIL to_send: got none expected tx_send"); end
      c = 0;
      while (c < 40 && timeout_err !== 1'b1) begin
         @(negedge clk);
         c++;
         tests_run++; if (ack !== '0) begin tests_failed++; $display("FAIL to_no_ack: got %0h expected 0", ack); end
      end
      tests_run++; if (c != BT + 1) begin tests_failed++; $display("FAIL to_cycles: got %0d expected %0d", c, BT + 1); end
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL to_active: got %0b expected 0", active); end
      req = 4'b0011; req_data[15:8] = 8'hC3;
      @(negedge clk);
      tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL to_pulse_width: got %0b expected 0", timeout_err); end
      tests_run++; if (tx_send !== 1'b1 || grant_id !== 2'd1) begin tests_failed++; $display("FAIL to_ptr_adv: got send=%0b grant=%0d expected 1/1", tx_send, grant_id); end
      tests_run++; if (tx_data !== 8'hC3) begin tests_failed++; $display("FAIL to_data1: got %0h expected c3", tx_data); end
      wait_sig(2, 40, cyc, hit);
      tests_run++; if (cyc != BT + 1) begin tests_failed++; $display("FAIL to_cycles2: got %0d expected %0d", cyc, BT + 1); end
      @(negedge clk);
      tests_run++; if (tx_send !== 1'b1 || grant_id !== 2'd0) begin tests_failed++; $display("FAIL to_retry: got send=%0b grant=%0d expected 1/0", tx_send, grant_id); end
      tests_run++; if (tx_data !== 8'h3C) begin tests_failed++; $display("FAIL to_retry_data: got %0h expected 3c", tx_data); end
      req = '0;
      wait_sig(2, 40, cyc, hit);
      tests_run++; if (!hit) begin tests_failed++; $display("FAIL to_final: got none expected timeout_err"); end
      dead = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit hit;
      int first;
      req = 4'b0100; req_data[23:16] = 8'h9C;
      wait_sig(0, 5, cyc, hit);
      repeat (4) @(negedge clk);
      tests_run++; if (active !== 1'b1) begin tests_failed++; $display("FAIL rm_active_before: got %0b expected 1", active); end
      rst_n = 1'b0;
      #1;
      tests_run++; if (active !== 1'b0) begin tests_failed++; $display("FAIL rm_active: got %0b expected 0", active); end
      tests_run++; if (tx_ena !== 1'b0) begin tests_failed++; $display("FAIL rm_ena: got %0b expected 0", tx_ena); end
      tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL rm_data: got %0h expected 00", tx_data); end
      tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL rm_grant: got %0d expected 0", grant_id); end
      tests_run++; if (ack !== '0) begin tests_failed++; $display("FAIL rm_ack: got %0h expected 0", ack); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first = 0;
      for (int c = 1; c <= 8 && first == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            tests_run++; if (tx_ena !== 1'b1) begin tests_failed++; $display("FAIL rm_ena_rise: got %0b expected 1", tx_ena); end
         end
         if (tx_send === 1'b1) first = c;
      end
      tests_run++; if (first != 3) begin tests_failed++; $display("FAIL rm_relaunch: got %0d expected 3", first); end
      wait_sig(1, 20, cyc, hit);
      tests_run++; if (ack !== 4'b0100) begin tests_failed++; $display("FAIL rm_ack_after: got %0h expected 4", ack); end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_startup();
      test_single();
      test_round_robin();
      test_withdraw();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter (8-bit data, `send`/`busy` handshake, `ena` enable) among N byte requesters. It latches the winning requester's byte and pulses the transmitter's `send` input. It holds `tx_data` stable for the whole frame, because the transmitter reads its data input live, bit by bit. It acknowledges the requester when the frame completes, and it detects a transmitter that never goes busy.

Parameters:
N, 4, number of requesters (2..8)
GW, 2, width of grant_id; must satisfy 2**GW >= N
BUSY_TIMEOUT, 15, max cycles to wait for tx_busy to rise after tx_send (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  per-requester level request; held high until matching ack
req_data  in  8*N  byte of requester i at bits [8i+7:8i]
ack  out  N  one-cycle pulse: requester's frame fully transmitted
grant_id  out  GW  index of current/last granted requester
active  out  1  high from grant until ack/abort
tx_ena  out  1  transmitter enable
tx_send  out  1  one-cycle send pulse to transmitter
tx_data  out  8  byte to transmitter, stable for whole frame
tx_busy  in  1  transmitter busy flag
timeout_err  out  1  one-cycle pulse: tx_busy never rose

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values (rst_n=0): state=IDLE, ptr=0, ack=0, grant_id=0, active=0, tx_ena=0, tx_send=0, tx_data=8'h00, timeout_err=0, timer=0.
- All outputs are registered.
- tx_ena goes 1 on the first clk edge after rst_n deasserts, then stays 1.
- The transmitter reports busy=1 while it initialises after enable. The arbiter therefore never launches while tx_busy=1.
- State IDLE:
  - Launch condition: tx_ena=1, tx_busy=0 and |req.
  - Selection: first set req bit searching ptr, ptr+1, …, N-1, 0, … (wraps).
  - On launch: latch tx_data=req_data[sel], grant_id=sel, active=1, and set tx_send=1 for exactly one cycle; go to WAIT_BUSY.
  - Otherwise stay in IDLE.
- State WAIT_BUSY:
  - tx_send returns to 0.
  - timer counts cycles spent in this state.
  - tx_busy=1 -> go to WAIT_DONE.
  - Timeout: if timer reaches BUSY_TIMEOUT with tx_busy still 0, pulse timeout_err, clear active, ptr=grant_id+1 (mod N), no ack; go to IDLE.
- State WAIT_DONE: wait for tx_busy=0. On that cycle, pulse ack[grant_id]=1, clear active, ptr=grant_id+1 (mod N); go to IDLE.
- Latency:
  - The earliest next launch is the cycle after ack, so requests are not granted back-to-back in the same cycle.
  - From req high in IDLE to tx_send high: 1 cycle.
- tx_data and grant_id hold their values from launch until the next launch, including through IDLE.
- Request withdrawal:
  - A req dropped before grant is simply not selected.
  - A req dropped or changed after grant has no effect: the frame completes and ack is still pulsed.
  - Changes to req_data after grant are ignored.
- The ack pulse and a new grant never occur in the same cycle.
- Fairness: with all requesters continuously requesting, grants go 0,1,…,N-1,0,…. No requester waits more than N-1 frames.
- Invalid states (encoding outside IDLE/WAIT_BUSY/WAIT_DONE) -> go to IDLE with active=0.
- Reset mid-frame: immediate return to reset values. tx_ena=0 forces the transmitter to its hold state. Any pending frame is dropped without ack.

Test Plan:
- Single requester: after reset, req[2]=1, req_data[2]=8'hA5, bus model with busy 1 cycle after send for 10 cycles → one tx_send pulse, tx_data=8'hA5 stable throughout, grant_id=2, ack[2] pulses once, active falls together with ack.
- All 4 requesting continuously with bytes 8'h11,8'h22,8'h33,8'h44 → grant order 0,1,2,3,0; serial line decodes 11,22,33,44; exactly one ack per frame.
- Withdraw and mutate:
  - req[1] high for 1 cycle, then dropped, while tx_busy=1 → never granted, no ack[1].
  - req[3] dropped and req_data[3] changed after grant → tx_data unchanged, ack[3] still pulses.
- Dead transmitter: tx_busy tied 0, req[0]=1 → tx_send pulse; timeout_err pulses exactly BUSY_TIMEOUT+1 cycles after tx_send; no ack; ptr advances; with req[0] held, retry follows.
- Reset mid-frame: rst_n=0 during WAIT_DONE → all outputs reset asynchronously, no ack. After release, tx_ena=1 on the next edge; no launch until tx_busy=0.
- Startup hold: transmitter model holds busy=1 for 1 cycle after tx_ena rises, req[0]=1 from reset → tx_send only after tx_busy falls.
